y86_instr_encoder: RTL and testbench

- Byte-serial Y86-64 instruction encoder and loader; the write-side counterpart of fetch.
- Accepts one decoded instruction (icode, ifun, rA, rB, valC) per handshake.
- Serialises it into the fetch byte format and writes it, one byte per cycle, into instruction memory at an auto-incrementing address.
- Used by test benches and the boot loader to build program images that the SEQ core then fetches.

---
 rtl/y86_instr_encoder.sv | 185 ++++++++++++++++++
 tb/tb_y86_instr_encoder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_instr_encoder.sv
// Byte-serial Y86-64 instruction encoder: serialises one decoded instruction into fetch byte order
// and writes it one byte per cycle at an auto-incrementing pointer. Define ENC_CHECKSUM_EN to build the running XOR checksum.
module y86_instr_encoder #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [63:0]       valC,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [ADDR_W-1:0] next_addr,
  output logic              invalid_instr,
  output logic              mem_error,
  output logic [7:0]        checksum
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_EMIT = 1'b1;

  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:         instr_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB:   instr_len = 4'd2;
      4'h7, 4'h8:               instr_len = 4'd9;
      4'h3, 4'h4, 4'h5:         instr_len = 4'd10;
      default:                  instr_len = 4'd0;
    endcase
  endfunction

  // Byte k of the encoding; valC follows the register byte when present, else b0 directly.
  function automatic logic [7:0] byte_sel(input logic [7:0] b0, input logic [7:0] regs,
                                          input logic [63:0] valc, input logic has_reg,
                                          input logic [3:0] k);
    logic [2:0] idx;
    idx = 3'(has_reg ? (k - 4'd2) : (k - 4'd1));
    if (k == 4'd0)                 byte_sel = b0;
    else if (has_reg && k == 4'd1) byte_sel = regs;
    else                           byte_sel = valc[{idx, 3'b000} +: 8];
  endfunction

  logic              state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        len_q, len_d;
  logic [7:0]        b0_q, b0_d;
  logic [7:0]        regs_q, regs_d;
  logic [63:0]       valc_q, valc_d;
  logic              has_reg_q, has_reg_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              invalid_q, invalid_d;
  logic              mem_err_q, mem_err_d;

  logic [3:0] in_len;
  logic       in_oob;

  assign in_len = instr_len(icode);
  // Compare against MEM_BYTES - len so a pointer loaded near the top of the address space cannot wrap past the check.
  assign in_oob = ptr_q > (MEM_LIMIT - ADDR_W'(in_len));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    b0_d        = b0_q;
    regs_d      = regs_q;
    valc_d      = valc_q;
    has_reg_d   = has_reg_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    invalid_d   = 1'b0;
    mem_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (addr_load) begin
          ptr_d = addr_in;
        end else if (in_valid) begin
          if (icode > 4'hB) begin
            invalid_d = 1'b1;
          end else if (in_oob) begin
            mem_err_d = 1'b1;
          end else begin
            b0_d        = {icode, ifun};
            regs_d      = {rA, rB};
            valc_d      = valC;
            len_d       = in_len;
            has_reg_d   = (in_len == 4'd2) || (in_len == 4'd10);
            cnt_d       = 4'd0;
            state_d     = ST_EMIT;
            mem_we_d    = 1'b1;
            mem_addr_d  = ptr_q;
            mem_wdata_d = {icode, ifun};
            if (in_len == 4'd1) ptr_d = ptr_q + ADDR_W'(1);
          end
        end
      end
      ST_EMIT: begin
        if (cnt_q == len_q - 4'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d       = cnt_q + 4'd1;
          mem_we_d    = 1'b1;
          mem_addr_d  = ptr_q + ADDR_W'(cnt_d);
          mem_wdata_d = byte_sel(b0_q, regs_q, valc_q, has_reg_q, cnt_d);
          if (cnt_d == len_q - 4'd1) ptr_d = ptr_q + ADDR_W'(len_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      invalid_q   <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      invalid_q   <= invalid_d;
      mem_err_q   <= mem_err_d;
    end
  end

  // NOTE: the latched instruction fields carry no reset; they are only read after an accept loads them.
  always_ff @(posedge clk) begin
    b0_q      <= b0_d;
    regs_q    <= regs_d;
    valc_q    <= valc_d;
    has_reg_q <= has_reg_d;
  end

`ifdef ENC_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk) begin
    if (rst)                                 csum_q <= 8'h00;
    else if (state_q == ST_IDLE && addr_load) csum_q <= 8'h00;
    else if (mem_we_d)                        csum_q <= csum_q ^ mem_wdata_d;
  end

  assign checksum = csum_q;
`else
  assign checksum = 8'h00;
`endif

  assign in_ready      = (state_q == ST_IDLE);
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign next_addr     = ptr_q;
  assign invalid_instr = invalid_q;
  assign mem_error     = mem_err_q;

endmodule

// File: tb/tb_y86_instr_encoder.sv
// Self-checking bench for y86_instr_encoder: a byte-image model predicts every write, pointer and pulse,
// and directed tests pin the model with literal byte images.
module tb_y86_instr_encoder;

  localparam int MEM_BYTES = 1024;

`ifdef ENC_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, addr_load, in_valid, in_ready;
  logic [63:0] addr_in;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC;
  logic        mem_we;
  logic [63:0] mem_addr, next_addr;
  logic [7:0]  mem_wdata, checksum;
  logic        invalid_instr, mem_error;

  y86_instr_encoder #(.MEM_BYTES(MEM_BYTES), .ADDR_W(64)) dut (
    .clk(clk), .rst(rst), .addr_load(addr_load), .addr_in(addr_in),
    .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .next_addr(next_addr), .invalid_instr(invalid_instr), .mem_error(mem_error),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  data;
    int          cyc;
    bit          last;
    logic [63:0] nxt;
  } wr_t;

  wr_t         exp_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          chk_en = 1'b0;
  logic [63:0] m_ptr = '0;
  logic [7:0]  m_csum = '0;
  logic [63:0] m_last_addr = '0;
  logic [7:0]  m_last_data = '0;
  int          exp_inv_cyc = -1;
  int          exp_err_cyc = -1;
  logic [7:0]  mem_img [0:MEM_BYTES-1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int spec_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       return 1;
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h7, 4'h8:             return 9;
      4'h3, 4'h4, 4'h5:       return 10;
      default:                return 0;
    endcase
  endfunction

  // Model decision at an accept edge e: queue the expected writes or arm the expected reject pulse.
  task automatic model_accept(input logic [3:0] ic, fn, ra, rb, input logic [63:0] vc,
                              input int e, output int len, output bit ok);
    logic [79:0] img;
    wr_t w;
    len = spec_len(ic);
    ok  = 1'b0;
    if (ic > 4'hB) exp_inv_cyc = e;
    else if (m_ptr + 64'(len) > 64'(MEM_BYTES)) exp_err_cyc = e;
    else begin
      ok  = 1'b1;
      img = (len == 2 || len == 10) ? {valC_pad(vc), ra, rb, ic, fn} : {8'h00, vc, ic, fn};
      for (int k = 0; k < len; k++) begin
        w.addr = m_ptr + 64'(k);
        w.data = img[8*k +: 8];
        w.cyc  = e + k;
        w.last = (k == len - 1);
        w.nxt  = m_ptr + 64'(len);
        exp_q.push_back(w);
      end
    end
  endtask

  function automatic logic [63:0] valC_pad(input logic [63:0] v);
    return v;
  endfunction

  // Compare process: every cycle, all outputs against the model.
  initial forever begin
    wr_t w;
    @(negedge clk);
    if (chk_en) begin
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected write", {63'd0, mem_we}, 64'd0);
        end else begin
          w = exp_q.pop_front();
          check("write addr", mem_addr, w.addr);
          check("write data", {56'd0, mem_wdata}, {56'd0, w.data});
          check("write cycle", 64'(cyc), 64'(w.cyc));
          if (w.last) m_ptr = w.nxt;
          m_csum = m_csum ^ w.data;
        end
        m_last_addr = mem_addr;
        m_last_data = mem_wdata;
        if (mem_addr < 64'(MEM_BYTES)) mem_img[mem_addr[9:0]] = mem_wdata;
      end else begin
        if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
          check("missing write", {63'd0, mem_we}, 64'd1);
          void'(exp_q.pop_front());
        end
        check("mem_addr hold", mem_addr, m_last_addr);
        check("mem_wdata hold", {56'd0, mem_wdata}, {56'd0, m_last_data});
      end
      check("next_addr", next_addr, m_ptr);
      check("checksum", {56'd0, checksum}, CSUM_ON ? {56'd0, m_csum} : 64'd0);
      check("invalid_instr", {63'd0, invalid_instr}, {63'd0, cyc == exp_inv_cyc});
      check("mem_error", {63'd0, mem_error}, {63'd0, cyc == exp_err_cyc});
    end
  end

  // Issue one instruction at the current negedge; returns at the negedge in_ready is back.
  task automatic send(input logic [3:0] ic, fn, ra, rb, input logic [63:0] vc, input bit garble);
    int e, len, rdy;
    bit ok;
    check("in_ready before send", {63'd0, in_ready}, 64'd1);
    icode = ic; ifun = fn; rA = ra; rB = rb; valC = vc; in_valid = 1'b1;
    @(posedge clk); #1;
    e = cyc;
    in_valid = 1'b0;
    model_accept(ic, fn, ra, rb, vc, e, len, ok);
    rdy = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        rdy = cyc;
        break;
      end
      if (garble) begin
        in_valid = 1'b1;
        icode = 4'($urandom); ifun = 4'($urandom);
        rA = 4'($urandom); rB = 4'($urandom);
        valC = {$urandom, $urandom};
      end
    end
    in_valid = 1'b0;
    check("in_ready return cycle", 64'(rdy), ok ? 64'(e + len) : 64'(e));
  endtask

  task automatic load(input logic [63:0] a, input bit with_valid);
    addr_load = 1'b1; addr_in = a;
    if (with_valid) begin
      icode = 4'h3; ifun = 4'h0; rA = 4'hF; rB = 4'h3; valC = 64'h0123456789ABCDEF;
      in_valid = 1'b1;
    end
    @(posedge clk); #1;
    addr_load = 1'b0; in_valid = 1'b0;
    m_ptr = a;
    m_csum = 8'h00;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] irm [10];
    logic [7:0] strm [12];
    int e;
    irm  = '{8'h30, 8'hF3, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    strm = '{8'h00, 8'h73, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h60, 8'h23};
    for (int i = 0; i < MEM_BYTES; i++) mem_img[i] = 8'hXX;

    rst = 1'b1; addr_load = 1'b0; addr_in = '0; in_valid = 1'b0;
    icode = '0; ifun = '0; rA = '0; rB = '0; valC = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset in_ready", {63'd0, in_ready}, 64'd1);
    check("reset mem_we", {63'd0, mem_we}, 64'd0);
    check("reset mem_addr", mem_addr, 64'd0);
    check("reset mem_wdata", {56'd0, mem_wdata}, 64'd0);
    check("reset next_addr", next_addr, 64'd0);
    check("reset pulses", {62'd0, invalid_instr, mem_error}, 64'd0);
    check("reset checksum", {56'd0, checksum}, 64'd0);
    chk_en = 1'b1;

    // irmovq $0x0123456789ABCDEF, %rbx
    send(4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, 1'b0);
    for (int i = 0; i < 10; i++) check("irmovq image", {56'd0, mem_img[i]}, {56'd0, irm[i]});
    check("irmovq next_addr", next_addr, 64'd10);
    check("irmovq checksum", {56'd0, checksum}, CSUM_ON ? 64'hC3 : 64'h0);

    // Back-to-back halt, jXX, OPq with garbage on the inputs while busy
    send(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 1'b1);
    send(4'h7, 4'h3, 4'hF, 4'hF, 64'h40, 1'b1);
    send(4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 1'b1);
    for (int i = 0; i < 12; i++) check("stream image", {56'd0, mem_img[10+i]}, {56'd0, strm[i]});
    check("stream next_addr", next_addr, 64'd22);

    // Invalid icode
    send(4'hC, 4'h0, 4'h1, 4'h2, 64'h55, 1'b0);
    check("invalid next_addr", next_addr, 64'd22);

    // Bound check near the top of memory
    load(64'd1020, 1'b0);
    check("addr_load next_addr", next_addr, 64'd1020);
    send(4'h4, 4'h0, 4'h1, 4'h2, 64'h8, 1'b0);
    send(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 1'b0);
    send(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 1'b0);
    send(4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 1'b0);
    check("top image 1020", {56'd0, mem_img[1020]}, 64'h10);
    check("top image 1021", {56'd0, mem_img[1021]}, 64'h00);
    check("top image 1022", {56'd0, mem_img[1022]}, 64'h60);
    check("top image 1023", {56'd0, mem_img[1023]}, 64'h23);
    check("exact fit next_addr", next_addr, 64'd1024);
    send(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 1'b0);
    send(4'hD, 4'h0, 4'hF, 4'hF, 64'h0, 1'b0);
    check("full next_addr", next_addr, 64'd1024);

    // addr_load wins over a simultaneous in_valid
    load(64'h30, 1'b1);
    repeat (3) @(negedge clk);
    check("load priority next_addr", next_addr, 64'h30);
    check("load clears checksum", {56'd0, checksum}, 64'd0);
    send(4'h6, 4'h1, 4'h2, 4'h3, 64'h0, 1'b0);
    check("post-load checksum", {56'd0, checksum}, CSUM_ON ? 64'h42 : 64'h0);
    check("post-load next_addr", next_addr, 64'h32);

    // Reset after the third byte of an irmovq
    icode = 4'h3; ifun = 4'h0; rA = 4'hF; rB = 4'h3; valC = 64'h0123456789ABCDEF; in_valid = 1'b1;
    @(posedge clk); #1;
    e = cyc;
    in_valid = 1'b0;
    begin
      int len; bit ok;
      model_accept(4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, e, len, ok);
    end
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    m_ptr = '0; m_csum = '0; m_last_addr = '0; m_last_data = '0;
    @(negedge clk);
    check("abort mem_we", {63'd0, mem_we}, 64'd0);
    check("abort next_addr", next_addr, 64'd0);
    check("abort in_ready", {63'd0, in_ready}, 64'd1);
    check("abort image 0x35", {56'd0, mem_img[8'h35]}, 64'hXX);
    repeat (12) @(negedge clk);
    send(4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 1'b0);
    check("after abort ret", {56'd0, mem_img[0]}, 64'h90);
    check("after abort next_addr", next_addr, 64'd1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
